// File: rtl/id_ex_pkg.sv
// Shared types and defaults for the ID/EX operand stage.
package id_ex_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int DEPTH_DEF = 5;

  // Stage control state: normal flow or the single bubble cycle after a load-use hazard.
  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Source chosen for one operand by the forwarding network.
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EX   = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority forwarding for one source operand: x0, then EX/MEM, then writeback,
// then the register-file read data.
module operand_fwd_mux
  import id_ex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DEPTH-1:0] src_addr,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             ex_en,
  input  logic [DEPTH-1:0] ex_addr,
  input  logic [WIDTH-1:0] ex_data,
  input  logic             wb_en,
  input  logic [DEPTH-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] operand
);

  fwd_sel_e sel;

  // Pick the youngest valid producer of src_addr; x0 always reads as zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    sel = FWD_RF;
    if (src_addr == '0)
      sel = FWD_ZERO;
    else if (ex_en && (ex_addr == src_addr))
      sel = FWD_EX;
    else if (wb_en && (wb_addr == src_addr))
      sel = FWD_WB;
  end

  // Route the selected source to the operand.
  always_comb begin
    operand = rf_data;
    case (sel)
      FWD_ZERO: operand = '0;
      FWD_EX:   operand = ex_data;
      FWD_WB:   operand = wb_data;
      default:  operand = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards rs1/rs2, registers operands and control for EX,
// and inserts a one-cycle bubble on a load-use hazard.
// Optional: define ID_EX_STALL_CNT_EN to add stall_cnt_o, a wrapping count of
// hazard bubbles.
module id_ex_operand_stage
  import id_ex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DEPTH-1:0] rs1_addr_i,
  input  logic [DEPTH-1:0] rs2_addr_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [DEPTH-1:0] rd_addr_i,
  input  logic             rd_wr_i,
  input  logic             is_load_i,
  input  logic             flush_i,
  input  logic             ex_fwd_en_i,
  input  logic [DEPTH-1:0] ex_fwd_addr_i,
  input  logic [WIDTH-1:0] ex_fwd_data_i,
  input  logic             wb_fwd_en_i,
  input  logic [DEPTH-1:0] wb_fwd_addr_i,
  input  logic [WIDTH-1:0] wb_fwd_data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  output logic [DEPTH-1:0] rd_addr_o,
  output logic             rd_wr_o,
  output logic             is_load_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);

  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic             hz;
  logic             capture;
  state_e           state_q;

  operand_fwd_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fwd_a (
    .src_addr (rs1_addr_i),
    .rf_data  (rs1_data_i),
    .ex_en    (ex_fwd_en_i),
    .ex_addr  (ex_fwd_addr_i),
    .ex_data  (ex_fwd_data_i),
    .wb_en    (wb_fwd_en_i),
    .wb_addr  (wb_fwd_addr_i),
    .wb_data  (wb_fwd_data_i),
    .operand  (fwd_a)
  );

  operand_fwd_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fwd_b (
    .src_addr (rs2_addr_i),
    .rf_data  (rs2_data_i),
    .ex_en    (ex_fwd_en_i),
    .ex_addr  (ex_fwd_addr_i),
    .ex_data  (ex_fwd_data_i),
    .wb_en    (wb_fwd_en_i),
    .wb_addr  (wb_fwd_addr_i),
    .wb_data  (wb_fwd_data_i),
    .operand  (fwd_b)
  );

  // A load sitting in EX cannot forward yet: the incoming consumer must wait a cycle.
  assign hz = valid_o && is_load_o && rd_wr_o && (rd_addr_o != '0) && valid_i &&
              ((rd_addr_o == rs1_addr_i) || (rd_addr_o == rs2_addr_i));

  assign ready_o = !hz && (!valid_o || ready_i);
  assign capture = valid_i && ready_o;

  // Pipeline register plus RUN/STALL control; reset beats flush beats capture.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_i) begin
      // NOTE: the payload registers are reset too, since EX sees all-zero fields out of reset.
      valid_o   <= 1'b0;
      op_a_o    <= '0;
      op_b_o    <= '0;
      rd_addr_o <= '0;
      rd_wr_o   <= 1'b0;
      is_load_o <= 1'b0;
      state_q   <= RUN;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      state_q <= RUN;
    end else begin
      if (capture) begin
        valid_o   <= 1'b1;
        op_a_o    <= fwd_a;
        op_b_o    <= fwd_b;
        rd_addr_o <= rd_addr_i;
        rd_wr_o   <= rd_wr_i;
        is_load_o <= is_load_i;
      end else if (ready_i) begin
        // Drain, including the bubble issued when the hazard stalls decode.
        valid_o <= 1'b0;
      end

      case (state_q)
        RUN:     if (hz && ready_i) state_q <= STALL;
        STALL:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Count bubbles caused by load-use hazards; flush leaves the count alone.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      stall_cnt_o <= '0;
    else if (!flush_i && (state_q == RUN) && hz && ready_i)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the stage.
module tb_id_ex_operand_stage;

  localparam int W = 64;
  localparam int D = 5;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         valid_i;
  logic         ready_o;
  logic [D-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [W-1:0] rs1_data_i, rs2_data_i;
  logic         rd_wr_i, is_load_i, flush_i;
  logic         ex_fwd_en_i, wb_fwd_en_i;
  logic [D-1:0] ex_fwd_addr_i, wb_fwd_addr_i;
  logic [W-1:0] ex_fwd_data_i, wb_fwd_data_i;
  logic         valid_o, ready_i;
  logic [W-1:0] op_a_o, op_b_o;
  logic [D-1:0] rd_addr_o;
  logic         rd_wr_o, is_load_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0]  stall_cnt_o;
`endif

  id_ex_operand_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rd_addr_i(rd_addr_i), .rd_wr_i(rd_wr_i), .is_load_i(is_load_i), .flush_i(flush_i),
    .ex_fwd_en_i(ex_fwd_en_i), .ex_fwd_addr_i(ex_fwd_addr_i), .ex_fwd_data_i(ex_fwd_data_i),
    .wb_fwd_en_i(wb_fwd_en_i), .wb_fwd_addr_i(wb_fwd_addr_i), .wb_fwd_data_i(wb_fwd_data_i),
    .valid_o(valid_o), .ready_i(ready_i), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .rd_addr_o(rd_addr_o), .rd_wr_o(rd_wr_o), .is_load_o(is_load_o)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What EX should currently be holding, plus the bubble count.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [D-1:0] m_rd = '0;
  logic         m_wr = 1'b0, m_ld = 1'b0;
  logic [31:0]  m_cnt = '0;

  function automatic logic [W-1:0] m_fwd(input logic [D-1:0] a, input logic [W-1:0] rf);
    if (a == 0) return '0;
    if (ex_fwd_en_i && ex_fwd_addr_i == a) return ex_fwd_data_i;
    if (wb_fwd_en_i && wb_fwd_addr_i == a) return wb_fwd_data_i;
    return rf;
  endfunction

  // The held instruction is a load whose result the incoming one needs.
  function automatic logic m_hazard();
    return m_valid && m_ld && m_wr && (m_rd != 0) && valid_i &&
           (m_rd == rs1_addr_i || m_rd == rs2_addr_i);
  endfunction

  function automatic logic m_ready();
    return !m_hazard() && (!m_valid || ready_i);
  endfunction

  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_valid <= 1'b0; m_a <= '0; m_b <= '0; m_rd <= '0; m_wr <= 1'b0; m_ld <= 1'b0;
      m_cnt   <= '0;
    end else if (flush_i) begin
      m_valid <= 1'b0;
    end else begin
      if (m_hazard() && ready_i) m_cnt <= m_cnt + 32'd1;
      if (valid_i && m_ready()) begin
        m_valid <= 1'b1;
        m_a     <= m_fwd(rs1_addr_i, rs1_data_i);
        m_b     <= m_fwd(rs2_addr_i, rs2_data_i);
        m_rd    <= rd_addr_i;
        m_wr    <= rd_wr_i;
        m_ld    <= is_load_i;
      end else if (ready_i) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("m_valid_o", valid_o, m_valid);
      check("m_ready_o", ready_o, m_ready());
      if (m_valid) begin
        check("m_op_a_o", op_a_o, m_a);
        check("m_op_b_o", op_b_o, m_b);
        check("m_rd_addr_o", rd_addr_o, m_rd);
        check("m_rd_wr_o", rd_wr_o, m_wr);
        check("m_is_load_o", is_load_o, m_ld);
      end
`ifdef ID_EX_STALL_CNT_EN
      check("m_stall_cnt_o", stall_cnt_o, m_cnt);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [D-1:0] r1, input logic [W-1:0] d1,
                           input logic [D-1:0] r2, input logic [W-1:0] d2,
                           input logic [D-1:0] rd, input logic wr, input logic ld);
    valid_i = v; rs1_addr_i = r1; rs1_data_i = d1; rs2_addr_i = r2; rs2_data_i = d2;
    rd_addr_i = rd; rd_wr_i = wr; is_load_i = ld;
  endtask

  task automatic set_fwd(input logic ee, input logic [D-1:0] ea, input logic [W-1:0] ed,
                         input logic we, input logic [D-1:0] wa, input logic [W-1:0] wd);
    ex_fwd_en_i = ee; ex_fwd_addr_i = ea; ex_fwd_data_i = ed;
    wb_fwd_en_i = we; wb_fwd_addr_i = wa; wb_fwd_data_i = wd;
  endtask

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    set_instr(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    set_fwd(1'b0, 0, 0, 1'b0, 0, 0);

    // Reset state
    step(); step();
    cmp_en = 1'b1;
    check("rst_valid_o", valid_o, 0);
    check("rst_op_a_o", op_a_o, 0);
    check("rst_ready_o", ready_o, 1);
    rst_n_i = 1'b1;

    // No hazard capture
    set_instr(1'b1, 1, 64'h1, 2, 64'h2, 7, 1'b1, 1'b0);
    step();
    set_instr(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    check("plain_valid_o", valid_o, 1);
    check("plain_op_a_o", op_a_o, 64'h1);
    check("plain_op_b_o", op_b_o, 64'h2);

    // Forwarding priority
    set_instr(1'b1, 3, 64'h55, 0, 64'h66, 8, 1'b1, 1'b0);
    set_fwd(1'b1, 3, 64'hAA, 1'b1, 3, 64'hBB);
    step();
    check("fwd_ex_op_a_o", op_a_o, 64'hAA);
    check("fwd_zero_rs2_op_b_o", op_b_o, 0);
    ex_fwd_en_i = 1'b0;
    step();
    check("fwd_wb_op_a_o", op_a_o, 64'hBB);
    set_instr(1'b1, 0, 64'h55, 0, 64'h66, 8, 1'b1, 1'b0);
    set_fwd(1'b1, 0, 64'hAA, 1'b1, 0, 64'hBB);
    step();
    check("fwd_x0_op_a_o", op_a_o, 0);
    set_fwd(1'b0, 0, 0, 1'b0, 0, 0);

    // Load-use hazard: load to x5, then consumer of x5 on rs2
    set_instr(1'b1, 0, 0, 0, 0, 5, 1'b1, 1'b1);
    step();
    set_instr(1'b1, 1, 64'h11, 5, 64'h99, 6, 1'b1, 1'b0);
    #1 check("lu_ready_o_low", ready_o, 0);
    step();
    check("lu_bubble_valid_o", valid_o, 0);
    set_fwd(1'b1, 5, 64'h1234, 1'b0, 0, 0);
    #1 check("lu_stall_ready_o", ready_o, 1);
    step();
    check("lu_valid_o", valid_o, 1);
    check("lu_op_a_o", op_a_o, 64'h11);
    check("lu_op_b_o", op_b_o, 64'h1234);
`ifdef ID_EX_STALL_CNT_EN
    check("lu_stall_cnt_o", stall_cnt_o, 1);
`endif
    set_fwd(1'b0, 0, 0, 1'b0, 0, 0);

    // Backpressure for 3 cycles
    ready_i = 1'b0;
    set_instr(1'b1, 1, 64'h77, 2, 64'h2, 9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready_o", ready_o, 0);
      step();
      check("bp_valid_o", valid_o, 1);
      check("bp_op_b_o", op_b_o, 64'h1234);
    end
    ready_i = 1'b1;
    #1 check("bp_release_ready_o", ready_o, 1);
    step();
    check("bp_capture_op_a_o", op_a_o, 64'h77);

    // Flush while in STALL with an incoming instruction
    set_instr(1'b1, 0, 0, 0, 0, 5, 1'b1, 1'b1);
    step();
    set_instr(1'b1, 5, 64'h3, 0, 0, 6, 1'b1, 1'b0);
    step();
    check("fl_bubble_valid_o", valid_o, 0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("fl_valid_o", valid_o, 0);
    step();
    check("fl_after_valid_o", valid_o, 0);
    check("fl_after_ready_o", ready_o, 1);

    // Reset during a held hazard with valid_o=1
    set_instr(1'b1, 0, 0, 0, 0, 5, 1'b1, 1'b1);
    step();
    set_instr(1'b1, 5, 64'h3, 0, 0, 6, 1'b1, 1'b0);
    ready_i = 1'b0;
    #1 check("rs_ready_o_low", ready_o, 0);
    step();
    check("rs_hold_valid_o", valid_o, 1);
    rst_n_i = 1'b0;
    step();
    check("rs_valid_o", valid_o, 0);
    check("rs_op_a_o", op_a_o, 0);
    check("rs_op_b_o", op_b_o, 0);
    check("rs_rd_addr_o", rd_addr_o, 0);
    check("rs_rd_wr_o", rd_wr_o, 0);
    check("rs_is_load_o", is_load_o, 0);
    check("rs_ready_o", ready_o, 1);
`ifdef ID_EX_STALL_CNT_EN
    check("rs_stall_cnt_o", stall_cnt_o, 0);
`endif
    rst_n_i = 1'b1;
    ready_i = 1'b1;

    // Randomized traffic, checked every cycle by the model comparison
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n_i = ($urandom_range(63) != 0);
      flush_i = ($urandom_range(15) == 0);
      ready_i = ($urandom_range(3) != 0);
      set_instr($urandom_range(3) != 0,
                D'($urandom_range(7)), {$urandom, $urandom},
                D'($urandom_range(7)), {$urandom, $urandom},
                D'($urandom_range(7)), $urandom_range(3) != 0, $urandom_range(1) == 1);
      set_fwd($urandom_range(1) == 1, D'($urandom_range(7)), {$urandom, $urandom},
              $urandom_range(1) == 1, D'($urandom_range(7)), {$urandom, $urandom});
    end
    step();
    @(negedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline stage directly downstream of the 64-bit, 32-entry register file (two combinational read ports, synchronous write).
- Takes rs1/rs2 read data, applies priority forwarding from EX/MEM and writeback, and registers the operands for EX.
- Detects load-use hazards, stalls upstream one cycle and inserts a bubble.
- Valid/ready handshake on both sides; flush support for branches.

Parameters:
WIDTH, 64, data width of operands and forwarded values
DEPTH, 5, register address width (2**DEPTH registers; x0 hardwired zero)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  synchronous active-low reset
valid_i  in  1  decode holds a valid instruction
ready_o  out  1  stage accepts instruction this cycle
rs1_addr_i  in  DEPTH  source 1 address (also drives register file addr_a)
rs2_addr_i  in  DEPTH  source 2 address (also drives register file addr_b)
rs1_data_i  in  WIDTH  register file data A
rs2_data_i  in  WIDTH  register file data B
rd_addr_i  in  DEPTH  destination address
rd_wr_i  in  1  instruction writes rd
is_load_i  in  1  instruction is a load
flush_i  in  1  kill registered instruction and any incoming one
ex_fwd_en_i  in  1  EX/MEM result valid for forwarding
ex_fwd_addr_i  in  DEPTH  EX/MEM destination
ex_fwd_data_i  in  WIDTH  EX/MEM result
wb_fwd_en_i  in  1  writeback enable (same signal as register file wr_en)
wb_fwd_addr_i  in  DEPTH  writeback address
wb_fwd_data_i  in  WIDTH  writeback data
valid_o  out  1  registered instruction valid for EX
ready_i  in  1  EX accepts
op_a_o  out  WIDTH  registered operand A
op_b_o  out  WIDTH  registered operand B
rd_addr_o  out  DEPTH  registered destination
rd_wr_o  out  1  registered write flag
is_load_o  out  1  registered load flag

Behaviour:
- Reset (rst_n_i=0 at a clock edge): valid_o, op_a_o, op_b_o, rd_addr_o, rd_wr_o, is_load_o = 0; FSM = RUN. Reset overrides flush and capture.
- Forwarding, per operand, combinational, in priority order:
  - address 0 -> 0;
  - ex_fwd_en_i and ex_fwd_addr_i match -> ex_fwd_data_i;
  - wb_fwd_en_i and wb_fwd_addr_i match -> wb_fwd_data_i (covers same-cycle write/read in the register file);
  - otherwise rs*_data_i.
- Hazard: hz = valid_o & is_load_o & rd_wr_o & (rd_addr_o != 0) & valid_i & (rd_addr_o == rs1_addr_i | rd_addr_o == rs2_addr_i).
- ready_o = !hz & (!valid_o | ready_i). Combinational; must not depend on valid_i except through hz.
- Capture: valid_i & ready_o -> all outputs load forwarded operands and control fields; valid_o=1. Latency 1 cycle.
- Hold: valid_o & !ready_i -> all outputs stable.
- Drain without new input: ready_i & !(valid_i & ready_o) -> valid_o=0. Data outputs may hold stale values.
- FSM RUN: if hz & ready_i -> valid_o=0 (bubble), go to STALL.
- FSM STALL: exactly one cycle; the load result is now on the ex_fwd_* inputs; ready_o follows the normal equation; return to RUN unconditionally.
- hz with !ready_i: stay RUN and hold; the hazard re-evaluates next cycle.
- flush_i: next edge valid_o=0, FSM=RUN, no capture that cycle. Flush beats capture and stall.
- rd_wr_i=0 instructions never cause a hazard downstream (is_load_o gated by rd_wr_o).

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined: adds output stall_cnt_o [31:0], reset to 0, incremented on each bubble inserted by hz. Wraps 0xFFFFFFFF -> 0. Not affected by flush.
- Undefined: no port, no counter logic.

Decomposition:
- Package id_ex_pkg: WIDTH/DEPTH defaults, FSM state enum {RUN, STALL}, forwarding select enum {FWD_ZERO, FWD_EX, FWD_WB, FWD_RF}.
- Sub-module operand_fwd_mux: combinational priority forwarding for one operand, instantiated twice.

Test Plan:
- No hazard: rs1=1, rs2=2, RF data 0x1/0x2, ready_i=1 -> next cycle valid_o=1, op_a_o=0x1, op_b_o=0x2.
- EX and WB both target x3 (0xAA vs 0xBB), rs1=3 -> op_a_o=0xAA; EX disabled -> 0xBB; rs1=0 with both targeting x0 -> 0.
- Load to x5 in stage, next instruction rs2=5 -> ready_o=0 one cycle, bubble (valid_o=0), STALL. Next cycle ex_fwd x5=0x1234 -> op_b_o=0x1234. With ID_EX_STALL_CNT_EN, stall_cnt_o=1.
- Backpressure: ready_i=0 for 3 cycles with valid_o=1 -> outputs constant, ready_o=0. Release -> next instruction captured.
- flush_i asserted with valid_i=1 and in STALL -> next cycle valid_o=0, FSM=RUN, incoming not captured.
- rst_n_i=0 mid-stall with valid_o=1 -> next edge all outputs 0, FSM=RUN, ready_o=1.
